// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memoryController port between fetch (I) and
//            load/store (D) requesters using an IDLE/ISSUE/RESP sequencer.
// Option   : ARB_ROUND_ROBIN_EN - round-robin arbitration in IDLE instead of
//            fixed D-over-I priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqI,
  input  logic [DATA_WIDTH-1:0] addrI,
  output logic                  doneI,
  output logic [DATA_WIDTH-1:0] rdataI,
  output logic                  errI,
  input  logic                  reqD,
  input  logic [DATA_WIDTH-1:0] addrD,
  input  logic [DATA_WIDTH-1:0] wdataD,
  input  logic [1:0]            lengthD,
  input  logic                  storeD,
  input  logic                  loadUnsignedD,
  output logic                  doneD,
  output logic [DATA_WIDTH-1:0] rdataD,
  output logic                  errD,
  output logic [DATA_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memDataWrite,
  output logic [1:0]            memLength,
  output logic                  memStore,
  output logic                  memLoad,
  output logic                  memLoadUnsigned,
  input  logic [DATA_WIDTH-1:0] memDataRead,
  input  logic                  memError
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic c_PORT_I = 1'b0;
  localparam logic c_PORT_D = 1'b1;

  state_t r_state;
  logic   r_owner;
  logic   r_last_grant;
  logic   r_err;

  logic   w_idle_pick_d;
  logic   w_grant;
  logic   w_grant_d;
  logic   w_resp;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention, favour whichever port was not granted most recently.
  assign w_idle_pick_d = reqD & (~reqI | (r_last_grant == c_PORT_I));
`else
  assign w_idle_pick_d = reqD;
`endif

  always_comb begin
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant   = reqI | reqD;
        w_grant_d = w_idle_pick_d;
      end
      RESP: begin
        // Hand-off only to the other port; the owner's held request is ignored.
        w_grant   = (r_owner == c_PORT_I) ? reqD : reqI;
        w_grant_d = (r_owner == c_PORT_I);
      end
      default: begin
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_owner         <= c_PORT_I;
      r_last_grant    <= c_PORT_I;
      r_err           <= 1'b0;
      memAddress      <= '0;
      memDataWrite    <= '0;
      memLength       <= 2'b00;
      memStore        <= 1'b0;
      memLoad         <= 1'b0;
      memLoadUnsigned <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (w_grant) begin
            r_state      <= ISSUE;
            r_owner      <= w_grant_d;
            r_last_grant <= w_grant_d;
            if (w_grant_d) begin
              memAddress      <= addrD;
              memDataWrite    <= wdataD;
              memLength       <= lengthD;
              memStore        <= storeD;
              memLoad         <= ~storeD;
              memLoadUnsigned <= loadUnsignedD;
            end else begin
              memAddress      <= addrI;
              memLength       <= 2'b10;
              memStore        <= 1'b0;
              memLoad         <= 1'b1;
              memLoadUnsigned <= 1'b0;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          memStore <= 1'b0;
          memLoad  <= 1'b0;
          r_err    <= memError;
          r_state  <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_resp = (r_state == RESP);
  assign doneI  = w_resp & (r_owner == c_PORT_I);
  assign doneD  = w_resp & (r_owner == c_PORT_D);
  assign rdataI = doneI ? memDataRead : '0;
  assign rdataD = doneD ? memDataRead : '0;
  assign errI   = doneI & r_err;
  assign errD   = doneD & r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int          MEM_WORDS = 16;
  localparam logic [31:0] MEM_BYTES = 32'd64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqI = 1'b0;
  logic [31:0] addrI = '0;
  logic        doneI;
  logic [31:0] rdataI;
  logic        errI;
  logic        reqD = 1'b0;
  logic [31:0] addrD = '0;
  logic [31:0] wdataD = '0;
  logic [1:0]  lengthD = 2'b00;
  logic        storeD = 1'b0;
  logic        loadUnsignedD = 1'b0;
  logic        doneD;
  logic [31:0] rdataD;
  logic        errD;
  logic [31:0] memAddress;
  logic [31:0] memDataWrite;
  logic [1:0]  memLength;
  logic        memStore;
  logic        memLoad;
  logic        memLoadUnsigned;
  logic [31:0] memDataRead;
  logic        memError;

  mem_port_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .reqI(reqI), .addrI(addrI), .doneI(doneI), .rdataI(rdataI), .errI(errI),
    .reqD(reqD), .addrD(addrD), .wdataD(wdataD), .lengthD(lengthD),
    .storeD(storeD), .loadUnsignedD(loadUnsignedD),
    .doneD(doneD), .rdataD(rdataD), .errD(errD),
    .memAddress(memAddress), .memDataWrite(memDataWrite), .memLength(memLength),
    .memStore(memStore), .memLoad(memLoad), .memLoadUnsigned(memLoadUnsigned),
    .memDataRead(memDataRead), .memError(memError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple RAM environment: registered read, out-of-range flag from address.
  logic [31:0] ram [MEM_WORDS];
  assign memError = (memAddress >= MEM_BYTES);
  always @(posedge clk) begin
    if (memLoad) begin
      memDataRead <= (memAddress < MEM_BYTES) ? ram[memAddress[5:2]] : 32'd0;
    end else if (memStore) begin
      if (memAddress < MEM_BYTES) ram[memAddress[5:2]] <= memDataWrite;
      memDataRead <= 32'd0;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction with its age since grant.
  logic [31:0] ref_mem [MEM_WORDS];
  bit          m_valid = 1'b0;
  int          m_age = 0;
  bit          m_port = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [1:0]  m_len = 2'b00;
  bit          m_store = 1'b0;
  bit          m_uns = 1'b0;
  bit          m_last = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e_rd;
    bit          e_err;
    bit          e_iss;
    bit          e_resp;
    bit          g;
    bit          p;
    e_iss  = !reset && m_valid && (m_age == 1);
    e_resp = !reset && m_valid && (m_age == 2);
    e_err  = (m_addr >= MEM_BYTES);
    e_rd   = (m_store || e_err) ? 32'd0 : ref_mem[m_addr[5:2]];

    check("doneI", doneI, e_resp && !m_port);
    check("doneD", doneD, e_resp && m_port);
    check("rdataI", rdataI, (e_resp && !m_port) ? e_rd : 32'd0);
    check("rdataD", rdataD, (e_resp && m_port) ? e_rd : 32'd0);
    check("errI", errI, e_resp && !m_port && e_err);
    check("errD", errD, e_resp && m_port && e_err);
    check("memLoad", memLoad, e_iss && !m_store);
    check("memStore", memStore, e_iss && m_store);
    if (e_iss) begin
      check("memAddress", memAddress, m_addr);
      check("memLength", memLength, m_len);
      check("memLoadUnsigned", memLoadUnsigned, m_uns);
      if (m_store) check("memDataWrite", memDataWrite, m_wdata);
    end
    if (reset) begin
      check("rst_memAddress", memAddress, 32'd0);
      check("rst_memDataWrite", memDataWrite, 32'd0);
      check("rst_memLength", memLength, 32'd0);
      check("rst_memLoadUnsigned", memLoadUnsigned, 32'd0);
    end

    if (reset) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end else if (m_valid && m_age == 1) begin
      m_age = 2;
    end else begin
      g = 1'b0;
      p = 1'b0;
      if (m_valid) begin
        if (m_store && !e_err) ref_mem[m_addr[5:2]] = m_wdata;
        p = !m_port;
        g = p ? reqD : reqI;
      end else if (reqI || reqD) begin
        g = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        p = (reqI && reqD) ? !m_last : reqD;
`else
        p = reqD;
`endif
      end
      m_valid = g;
      if (g) begin
        m_age  = 1;
        m_port = p;
        m_last = p;
        if (p) begin
          m_addr = addrD; m_wdata = wdataD; m_len = lengthD;
          m_store = storeD; m_uns = loadUnsignedD;
        end else begin
          m_addr = addrI; m_wdata = 32'd0; m_len = 2'b10;
          m_store = 1'b0; m_uns = 1'b0;
        end
      end
    end
  end

  task automatic run_d(input logic [31:0] a, input logic [31:0] w, input logic [1:0] len,
                       input bit st, input bit un,
                       output int lat, output logic [31:0] rd, output logic er);
    int start;
    bit seen;
    @(posedge clk); #1;
    reqD = 1'b1; addrD = a; wdataD = w; lengthD = len; storeD = st; loadUnsignedD = un;
    start = cyc; seen = 1'b0; lat = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (doneD) begin seen = 1'b1; lat = cyc - start; rd = rdataD; er = errD; end
    end
    @(posedge clk); #1;
    reqD = 1'b0; storeD = 1'b0;
  endtask

  task automatic run_i(input logic [31:0] a, output int lat, output logic [31:0] rd, output logic er);
    int start;
    bit seen;
    @(posedge clk); #1;
    reqI = 1'b1; addrI = a;
    start = cyc; seen = 1'b0; lat = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (doneI) begin seen = 1'b1; lat = cyc - start; rd = rdataI; er = errI; end
    end
    @(posedge clk); #1;
    reqI = 1'b0;
  endtask

  initial begin
    int          lat_i, lat_d, n, last_c;
    logic [31:0] rd_i, rd_d;
    logic        er_i, er_d;
    bit          saw, both, alt_ok, prev, first, cur;

    for (int i = 0; i < MEM_WORDS; i++) begin
      ram[i]     = 32'h01010101 * i;
      ref_mem[i] = 32'h01010101 * i;
    end
    ram[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
    ram[12] = 32'hCAFEF00D; ref_mem[12] = 32'hCAFEF00D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_doneI", doneI, 32'd0);
    check("reset_doneD", doneD, 32'd0);
    check("reset_memLoad", memLoad, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    run_i(32'h10, lat_i, rd_i, er_i);
    check("fetch_lat", lat_i, 32'd2);
    check("fetch_rdata", rd_i, 32'hDEADBEEF);
    check("fetch_err", er_i, 32'd0);

    run_d(32'h20, 32'h11223344, 2'b10, 1'b1, 1'b0, lat_d, rd_d, er_d);
    check("store_lat", lat_d, 32'd2);
    check("store_err", er_d, 32'd0);
    run_d(32'h20, 32'h0, 2'b10, 1'b0, 1'b1, lat_d, rd_d, er_d);
    check("load_lat", lat_d, 32'd2);
    check("load_rdata", rd_d, 32'h11223344);

    // Simultaneous requests; last grant was D.
    fork
      run_i(32'h10, lat_i, rd_i, er_i);
      run_d(32'h20, 32'h0, 2'b10, 1'b0, 1'b0, lat_d, rd_d, er_d);
    join
`ifdef ARB_ROUND_ROBIN_EN
    check("sim_lat_i", lat_i, 32'd2);
    check("sim_lat_d", lat_d, 32'd4);
`else
    check("sim_lat_d", lat_d, 32'd2);
    check("sim_lat_i", lat_i, 32'd4);
`endif
    check("sim_rdata_i", rd_i, 32'hDEADBEEF);
    check("sim_rdata_d", rd_d, 32'h11223344);

    run_d(MEM_BYTES, 32'h0, 2'b10, 1'b0, 1'b0, lat_d, rd_d, er_d);
    check("oor_lat", lat_d, 32'd2);
    check("oor_err", er_d, 32'd1);

    // Reset during ISSUE of a store.
    @(posedge clk); #1;
    reqD = 1'b1; addrD = 32'h30; wdataD = 32'h55667788; storeD = 1'b1; lengthD = 2'b10;
    @(posedge clk); #1;
    check("iss_memStore", memStore, 32'd1);
    reset = 1'b1;
    #1 check("rst_memStore_drop", memStore, 32'd0);
    reqD = 1'b0; storeD = 1'b0;
    saw = 1'b0;
    repeat (3) begin @(negedge clk); if (doneD) saw = 1'b1; end
    check("rst_no_done", saw, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_d(32'h30, 32'h0, 2'b10, 1'b0, 1'b0, lat_d, rd_d, er_d);
    check("after_rst_rdata", rd_d, 32'hCAFEF00D);

    // Continuous contention for 20 cycles.
    @(posedge clk); #1;
    reqI = 1'b1; addrI = 32'h08;
    reqD = 1'b1; addrD = 32'h04; storeD = 1'b0; lengthD = 2'b10; loadUnsignedD = 1'b0;
    n = 0; both = 1'b0; alt_ok = 1'b1; prev = 1'b0; first = 1'b0; last_c = 0;
    repeat (20) begin
      @(negedge clk);
      if (doneI && doneD) both = 1'b1;
      if (doneI || doneD) begin
        cur = doneD;
        if (n == 0) first = cur;
        else if (cur == prev || (cyc - last_c) != 2) alt_ok = 1'b0;
        prev = cur; last_c = cyc; n++;
      end
    end
    @(posedge clk); #1;
    reqI = 1'b0; reqD = 1'b0;
    repeat (4) @(posedge clk);
    check("cont_both", both, 32'd0);
    check("cont_alternate", alt_ok, 32'd1);
    check("cont_count", n, 32'd9);
`ifdef ARB_ROUND_ROBIN_EN
    check("cont_first_is_d", first, 32'd0);
`else
    check("cont_first_is_d", first, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
